// File: rtl/unary_pkg.sv
// Shared types for the unary accumulator: FSM state encoding and lane limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package unary_pkg;

    // Largest supported number of unary input lanes.
    localparam int LANES_MAX = 16;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Width needed to hold a popcount of 'lanes' bits (0..lanes).
    function automatic int pc_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/unary_add_n_if.sv
// Control/data bundle between the unary accumulator and its driver.
// Latency: n/a (wires only).
// Backpressure: none; en is the only stall mechanism.
interface unary_add_n_if #(
    parameter int LANES = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             mode;
    logic [LANES-1:0] din;
    logic             dout;
    logic             ovf;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] count_o;

    modport master (
        output en, clr, mode, din,
        input  dout, ovf, done, busy, count_o
    );

    modport slave (
        input  en, clr, mode, din,
        output dout, ovf, done, busy, count_o
    );
endinterface

// File: rtl/unary_popcount.sv
// Purely combinational count of set bits across the unary input lanes.
// Latency: 0 cycles.
// Backpressure: none.
module unary_popcount
    import unary_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES-1:0]             din_i,
    output logic [pc_width(LANES)-1:0]   cnt_o
);
    localparam int PW = pc_width(LANES);

    // Ripple sum of the lane bits; LANES is small so a plain adder chain is fine.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < LANES; i++) begin
            cnt_o = cnt_o + PW'(din_i[i]);
        end
    end
endmodule

// File: rtl/unary_add_n.sv
// Unary accumulator: adds popcount(din) per enabled cycle, then drains the total as a serial run of dout=1 cycles.
// Latency: count_o/ovf update on the edge after the input; a drain of N gives N dout pulses starting one cycle after DRAIN entry, then done.
// Backpressure: none; en low freezes all state and outputs. Build option UNARY_ADD_SAT_EN clamps on overflow instead of wrapping.
module unary_add_n
    import unary_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    unary_add_n_if.slave bus
);
    localparam int PW = pc_width(LANES);

    if (LANES < 1 || LANES > LANES_MAX) begin : g_bad_lanes
        $error("unary_add_n: LANES out of range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [PW-1:0]    pc;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] acc_val;

    unary_popcount #(.LANES(LANES)) u_popcount (
        .din_i (bus.din),
        .cnt_o (pc)
    );

    // One extra bit so the overflow compare sees the untruncated sum.
    assign sum = {1'b0, count_q} + (CNT_W+1)'(pc);

`ifdef UNARY_ADD_SAT_EN
    assign acc_val = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
    assign acc_val = sum[CNT_W-1:0];
`endif

    // Next state and registered outputs; nothing moves unless en is high, clr wins over everything else.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        done_d  = done_q;
        if (bus.en) begin
            dout_d = 1'b0;
            ovf_d  = 1'b0;
            done_d = 1'b0;
            if (bus.clr) begin
                state_d = ACC;
                count_d = '0;
            end else begin
                case (state_q)
                    ACC: begin
                        if (bus.mode) begin
                            state_d = DRAIN;
                        end else begin
                            ovf_d   = sum[CNT_W];
                            count_d = acc_val;
                        end
                    end
                    DRAIN: begin
                        if (count_q != '0) begin
                            dout_d  = 1'b1;
                            count_d = count_q - CNT_W'(1);
                        end else begin
                            done_d  = 1'b1;
                            state_d = HOLD;
                        end
                    end
                    HOLD: begin
                        if (!bus.mode) begin
                            state_d = ACC;
                        end
                    end
                    default: state_d = ACC;
                endcase
            end
        end
        busy_d = (state_d == DRAIN);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            count_q <= '0;
            dout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.ovf     = ovf_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.count_o = count_q;

endmodule

// File: doc/unary_add_n.md
UNARY_ADD_N -- requirements
Module: unary_add_n

Interface
REQ-001 The block SHALL have parameter LANES, default 4, meaning the number of unary input lanes summed per cycle (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the accumulator width in bits (CNT_W >= clog2(LANES+1)).
REQ-003 The block SHALL have port clk, input, 1, meaning the system clock.
REQ-004 The block SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, meaning the global cycle enable; when low, all state and outputs hold.
REQ-006 The block SHALL have port clr, input, 1, meaning a synchronous clear of the accumulator and state, qualified by en.
REQ-007 The block SHALL have port mode, input, 1, meaning 0 = accumulate and 1 = drain request.
REQ-008 The block SHALL have port din, input, LANES, meaning unary input bits, each 1 adding one to the count.
REQ-009 The block SHALL have port dout, output, 1, meaning the serial unary result stream.
REQ-010 The block SHALL have port ovf, output, 1, meaning a one-cycle overflow pulse.
REQ-011 The block SHALL have port done, output, 1, meaning a one-cycle pulse on drain completion.
REQ-012 The block SHALL have port busy, output, 1, meaning high while in the DRAIN state.
REQ-013 The block SHALL have port count_o, output, CNT_W, meaning the live accumulator value.

Function
REQ-014 The block SHALL implement FSM states ACC, DRAIN and HOLD; all transitions SHALL occur only on cycles with en=1.
REQ-015 In ACC with mode=0, count SHALL become count + popcount(din) on the next edge, and dout SHALL be 0.
REQ-016 ovf SHALL pulse high for one cycle exactly when count + popcount(din) > 2^CNT_W - 1, computed at CNT_W+1 bits with no truncation before the compare.
REQ-017 In ACC with mode=1, the FSM SHALL enter DRAIN with din ignored; dout SHALL be 0 on that edge.
REQ-018 In DRAIN with count != 0, dout SHALL be 1 and count SHALL decrement by 1 per enabled cycle, independent of mode.
REQ-019 In DRAIN with count == 0, dout SHALL be 0, done SHALL pulse for one cycle, and the FSM SHALL move to HOLD.
REQ-020 A drain started with count == 0 SHALL produce done one cycle after DRAIN entry, with no dout pulses.
REQ-021 HOLD SHALL keep dout=0 and return to ACC on the first enabled cycle with mode=0.
REQ-022 A drain from value N SHALL produce exactly N consecutive dout=1 cycles (with en held high), starting one cycle after DRAIN entry.
REQ-023 clr with en=1 SHALL set count=0 and state=ACC, and clear dout, ovf and done; clr SHALL take priority over mode and din, including mid-drain.
REQ-024 busy SHALL be a registered output equal to (state == DRAIN).

Reset
REQ-025 rst_n low SHALL asynchronously force count=0, state=ACC and dout=ovf=done=busy=0.
REQ-026 Reset deassertion SHALL be synchronised externally; the block SHALL resume in ACC on the first enabled edge.

Configuration
REQ-027 With UNARY_ADD_SAT_EN defined, an overflowing accumulate SHALL clamp count at 2^CNT_W - 1, and ovf SHALL still pulse.
REQ-028 Without UNARY_ADD_SAT_EN, an overflowing accumulate SHALL wrap modulo 2^CNT_W (count = sum - 2^CNT_W).

Structure
REQ-029 The FSM state enum (ACC, DRAIN, HOLD) and the LANES maximum constant SHALL reside in the shared package unary_pkg.
REQ-030 Lane summation SHALL be a combinational sub-module unary_popcount (parameter LANES, output clog2(LANES+1) bits), instantiated once.

Verification
REQ-031 The bench SHALL apply LANES=4, CNT_W=8, din=4'b1011 for 3 enabled cycles, then mode=1 -> count_o=9, then 9 dout pulses, then a done pulse, with busy high throughout the drain.
REQ-032 The bench SHALL preload count=253 and apply din=4'b1111 -> ovf pulses once; count_o=255 with UNARY_ADD_SAT_EN, count_o=1 without it.
REQ-033 The bench SHALL set mode=1 with count=0 -> no dout pulse, and done one cycle after DRAIN entry.
REQ-034 The bench SHALL toggle en low for 2 cycles mid-drain from 5 -> dout and count_o freeze, and exactly 5 dout=1 cycles total.
REQ-035 The bench SHALL assert clr on the 3rd drain cycle from count 6 -> next cycle count_o=0, dout=0, busy=0, no done pulse.
REQ-036 The bench SHALL pulse rst_n low asynchronously mid-accumulate at count 40 -> all outputs 0 immediately, and the FSM in ACC.
